// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - ss.cc countdown timer with start/pause, expiry pulse and seven-segment outputs
// Define COUNTDOWN_BLINK_EN to blink the expired 00.00 display in 50-centisecond phases.
module countdown_timer #(
  parameter int TICKS_PER_CS = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       load,
  input  logic [6:0] preset_sec,
  input  logic       start_stop,
  output logic       running,
  output logic       done,
  output logic [6:0] HEX7,
  output logic [6:0] HEX6,
  output logic [6:0] HEX5,
  output logic [6:0] HEX4
);

  localparam int            PW        = $clog2(TICKS_PER_CS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_CS - 1);
  localparam logic [6:0]    SEG_OFF   = 7'b1111111;
  localparam logic [6:0]    SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    s1_q, s1_d, s0_q, s0_d, c1_q, c1_d, c0_q, c0_d;
  logic          running_q, running_d, done_q, done_d;
  logic [6:0]    hex7_q, hex7_d, hex6_q, hex6_d, hex5_q, hex5_d, hex4_q, hex4_d;
  logic          presc_en, tick, nonzero, last_cs, blank;
  logic [6:0]    clamp;
`ifdef COUNTDOWN_BLINK_EN
  logic [5:0]    blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_OFF;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    s1_d    = s1_q;
    s0_d    = s0_q;
    c1_d    = c1_q;
    c0_d    = c0_q;
    done_d  = 1'b0;
    clamp   = (preset_sec > 7'd99) ? 7'd99 : preset_sec;
    nonzero = |{s1_q, s0_q, c1_q, c0_q};
    last_cs = ({s1_q, s0_q, c1_q} == 12'd0) && (c0_q == 4'd1);
`ifdef COUNTDOWN_BLINK_EN
    presc_en = (state_q == S_RUN) || (state_q == S_EXPIRED);
`else
    presc_en = (state_q == S_RUN);
`endif
    tick = presc_en && (presc_q == PRESC_MAX);
    if (presc_en) presc_d = tick ? '0 : presc_q + PW'(1);

    if (load) begin
      s1_d    = 4'(clamp / 7'd10);
      s0_d    = 4'(clamp % 7'd10);
      c1_d    = 4'd0;
      c0_d    = 4'd0;
      presc_d = '0;
      state_d = S_IDLE;
    end else begin
      // Ripple borrow c0 -> c1 -> s0 -> s1; the expiring tick itself wraps the prescaler to 0.
      if (state_q == S_RUN && tick) begin
        if (c0_q != 4'd0) c0_d = c0_q - 4'd1;
        else begin
          c0_d = 4'd9;
          if (c1_q != 4'd0) c1_d = c1_q - 4'd1;
          else begin
            c1_d = 4'd9;
            if (s0_q != 4'd0) s0_d = s0_q - 4'd1;
            else begin
              s0_d = 4'd9;
              s1_d = s1_q - 4'd1;
            end
          end
        end
        if (last_cs) begin
          state_d = S_EXPIRED;
          done_d  = 1'b1;
        end
      end
      if (start_stop && state_d != S_EXPIRED) begin
        case (state_q)
          S_IDLE:  if (nonzero) state_d = S_RUN;
          S_RUN:   state_d = S_PAUSE;
          S_PAUSE: state_d = S_RUN;
          default: ;
        endcase
      end
    end

    running_d = (state_d == S_RUN);

`ifdef COUNTDOWN_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (state_q == S_EXPIRED && tick) begin
      if (blink_cnt_q == 6'd49) begin
        blink_cnt_d = 6'd0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 6'd1;
      end
    end
    if (state_q != S_EXPIRED || state_d != S_EXPIRED) begin
      blink_cnt_d = 6'd0;
      blink_off_d = 1'b0;
    end
    blank = blink_off_q;
`else
    blank = 1'b0;
`endif

    hex7_d = blank ? SEG_OFF : seg7(s1_q);
    hex6_d = blank ? SEG_OFF : seg7(s0_q);
    hex5_d = blank ? SEG_OFF : seg7(c1_q);
    hex4_d = blank ? SEG_OFF : seg7(c0_q);
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      s1_q        <= 4'd0;
      s0_q        <= 4'd0;
      c1_q        <= 4'd0;
      c0_q        <= 4'd0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      hex7_q      <= SEG_ZERO;
      hex6_q      <= SEG_ZERO;
      hex5_q      <= SEG_ZERO;
      hex4_q      <= SEG_ZERO;
`ifdef COUNTDOWN_BLINK_EN
      blink_cnt_q <= 6'd0;
      blink_off_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      s1_q        <= s1_d;
      s0_q        <= s0_d;
      c1_q        <= c1_d;
      c0_q        <= c0_d;
      running_q   <= running_d;
      done_q      <= done_d;
      hex7_q      <= hex7_d;
      hex6_q      <= hex6_d;
      hex5_q      <= hex5_d;
      hex4_q      <= hex4_d;
`ifdef COUNTDOWN_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
`endif
    end
  end

  assign running = running_q;
  assign done    = done_q;
  assign HEX7    = hex7_q;
  assign HEX6    = hex6_q;
  assign HEX5    = hex5_q;
  assign HEX4    = hex4_q;

endmodule
